// File: rtl/ipv4_deparse_512.sv
// IPv4 header deparser on a 512-bit streaming bus: patches TTL/addresses/checksum
// into the second beat of each packet through a fixed three-stage pipeline.
module ipv4_deparse_512 #(
   parameter int          NODE_ID     = 4,
   parameter int          NOC_RADIX   = 16,
   parameter int          NUM_VC      = 2,
   parameter logic [((NOC_RADIX > 1) ? $clog2(NOC_RADIX) : 1)-1:0] DEST_PORT = 4'd0,
   parameter logic [7:0]  DEFAULT_TTL = 8'd64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_sop,
   input  logic         in_eop,
   input  logic         in_error,
   input  logic [5:0]   in_empty,
   input  logic [511:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_sop,
   output logic         out_eop,
   output logic         out_error,
   output logic [5:0]   out_empty,
   output logic [511:0] out_data,
   output logic [((NUM_VC > 1) ? $clog2(NUM_VC) : 1)-1:0]       o_vc_id,
   output logic [((NOC_RADIX > 1) ? $clog2(NOC_RADIX) : 1)-1:0] o_noc_dst,
   output logic [15:0]  o_drop_cnt
);

   // state | meaning
   // IDLE  | waiting for SOP; non-SOP beats are dropped and counted
   // HDR   | next beat carries the IPv4 header at byte offset P-20
   // BODY  | payload beats pass unchanged until EOP
   typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

   // Header bytes 0, 8 and 10..19 are overwritten; checksum bytes are zeroed here.
   localparam logic [159:0] HDR_MASK = {8'hFF, 56'h0, 8'hFF, 8'h00, {80{1'b1}}};

   state_t        state, state_nxt;
   logic [6:0]    p_r, p_nxt;
   logic [31:0]   src_r, src_nxt, dst_r, dst_nxt;
   logic          bad_r, bad_nxt;
   logic [15:0]   drop_cnt;

   logic          acc, fwd, drop, beat_err, beat_patch;
   logic [511:0]  beat_data, patched;
   logic [6:0]    sop_p, h;
   logic          sop_bad;
   logic [9:0]    sh;
   logic [159:0]  hdr_val, hdr_top;
   logic [16:0]   pair [5];

   logic          s1_v, s2_v, s3_v;
   logic [511:0]  s1_data, s2_data, s3_data;
   logic          s1_sop, s1_eop, s1_err, s1_patch;
   logic          s2_sop, s2_eop, s2_err, s2_patch;
   logic          s3_sop, s3_eop, s3_err;
   logic [5:0]    s1_empty, s2_empty, s3_empty;
   logic [6:0]    s1_h, s2_h;
   logic [16:0]   s1_pair [5];
   logic [19:0]   s2_sum;
   logic [16:0]   fold1;
   logic [15:0]   fold2, csum;
   logic [511:0]  csum_ins;

   assign in_ready = out_ready;
   assign acc      = in_valid & out_ready;
   assign sop_p    = in_data[478:472];
   assign sop_bad  = (sop_p < 7'd20) || (sop_p > 7'd64);
   assign h        = p_r - 7'd20;
   assign sh       = {h, 3'b000};
   assign hdr_val  = {8'h45, 56'h0, DEFAULT_TTL, 8'h00, 16'h0000, src_r, dst_r};
   assign patched  = (in_data & ~({HDR_MASK, 352'b0} >> sh)) | ({hdr_val, 352'b0} >> sh);
   assign hdr_top  = 160'((patched << sh) >> 352);

   always_comb begin
      for (int i = 0; i < 5; i++) begin
         pair[i] = {1'b0, hdr_top[159-32*i -: 16]} + {1'b0, hdr_top[143-32*i -: 16]};
      end
   end

   always_comb begin
      state_nxt  = state;
      p_nxt      = p_r;
      src_nxt    = src_r;
      dst_nxt    = dst_r;
      bad_nxt    = bad_r;
      fwd        = 1'b0;
      drop       = 1'b0;
      beat_data  = in_data;
      beat_err   = in_error;
      beat_patch = 1'b0;
      if (acc) begin
         if (in_sop) begin
            fwd       = 1'b1;
            p_nxt     = sop_p;
            src_nxt   = in_data[452:421];
            dst_nxt   = in_data[420:389];
            bad_nxt   = sop_bad;
            state_nxt = in_eop ? IDLE : HDR;
            if (sop_bad || in_eop) beat_err = 1'b1;
            else beat_data[478:472] = sop_p - 7'd20;
         end else begin
            case (state)
               HDR: begin
                  fwd       = 1'b1;
                  state_nxt = in_eop ? IDLE : BODY;
                  beat_err  = in_error | bad_r;
                  if (!bad_r) begin
                     beat_data  = patched;
                     beat_patch = 1'b1;
                  end
               end
               BODY: begin
                  fwd      = 1'b1;
                  beat_err = in_error | bad_r;
                  if (in_eop) state_nxt = IDLE;
               end
               default: drop = 1'b1;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         p_r      <= '0;
         src_r    <= '0;
         dst_r    <= '0;
         bad_r    <= 1'b0;
         drop_cnt <= '0;
      end else begin
         state <= state_nxt;
         p_r   <= p_nxt;
         src_r <= src_nxt;
         dst_r <= dst_nxt;
         bad_r <= bad_nxt;
         if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
         s3_v <= 1'b0;
      end else if (out_ready) begin
         s1_v <= fwd;
         s2_v <= s1_v;
         s3_v <= s2_v;
      end
   end

   assign fold1    = {1'b0, s2_sum[15:0]} + {13'b0, s2_sum[19:16]};
   assign fold2    = fold1[15:0] + {15'b0, fold1[16]};
   assign csum     = ~fold2;
   assign csum_ins = s2_patch ? ({496'b0, csum} << (10'd416 - {s2_h, 3'b000})) : '0;

   // Payload registers carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (out_ready) begin
         s1_data  <= beat_data;
         s1_sop   <= in_sop;
         s1_eop   <= in_eop;
         s1_err   <= beat_err;
         s1_empty <= in_empty;
         s1_patch <= beat_patch;
         s1_h     <= h;
         for (int i = 0; i < 5; i++) s1_pair[i] <= pair[i];

         s2_data  <= s1_data;
         s2_sop   <= s1_sop;
         s2_eop   <= s1_eop;
         s2_err   <= s1_err;
         s2_empty <= s1_empty;
         s2_patch <= s1_patch;
         s2_h     <= s1_h;
         s2_sum   <= {3'b0, s1_pair[0]} + {3'b0, s1_pair[1]} + {3'b0, s1_pair[2]}
                   + {3'b0, s1_pair[3]} + {3'b0, s1_pair[4]};

         s3_data  <= s2_data | csum_ins;
         s3_sop   <= s2_sop;
         s3_eop   <= s2_eop;
         s3_err   <= s2_err;
         s3_empty <= s2_empty;
      end
   end

   assign out_valid  = s3_v;
   assign out_data   = s3_v ? s3_data : '0;
   assign out_sop    = s3_v & s3_sop;
   assign out_eop    = s3_v & s3_eop;
   assign out_error  = s3_v & s3_err;
   assign out_empty  = s3_v ? s3_empty : '0;
   assign o_noc_dst  = s3_v ? DEST_PORT : '0;
   assign o_vc_id    = '0;
   assign o_drop_cnt = drop_cnt;

   assert property (@(posedge clk) reset |=> !out_valid)
      else $error("ipv4_deparse_512 node %0d: output valid after reset", NODE_ID);

endmodule

// File: tb/tb_ipv4_deparse_512.sv
// Scoreboard bench for ipv4_deparse_512: directed packets with hand-computed
// expected beats, checked by an independent output monitor.
module tb_ipv4_deparse_512;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid, in_ready, in_sop, in_eop, in_error;
   logic [5:0]   in_empty;
   logic [511:0] in_data;
   logic         out_valid, out_ready, out_sop, out_eop, out_error;
   logic [5:0]   out_empty;
   logic [511:0] out_data;
   logic [0:0]   o_vc_id;
   logic [3:0]   o_noc_dst;
   logic [15:0]  o_drop_cnt;

   localparam logic [3:0]   DEST    = 4'd5;
   localparam logic [159:0] HDR_IN  = 160'h45000073_00004000_00110000_00000000_00000000;
   localparam logic [159:0] HDR_OUT = 160'h45000073_00004000_4011B861_C0A80001_C0A800C7;

   typedef struct {
      logic [511:0] data;
      logic         sop;
      logic         eop;
      logic         err;
      logic [5:0]   empty;
   } beat_t;

   beat_t exp_q[$];
   int    tag_q[$];
   int    errors = 0;
   int    checks = 0;
   int    rdy_cnt = 0;
   int    cyc = 0;
   int    stall_at = -100;
   logic  in_fwd = 1'b0;

   always #5 clk = ~clk;

   ipv4_deparse_512 #(.DEST_PORT(DEST)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop),
      .in_error(in_error), .in_empty(in_empty), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
      .out_error(out_error), .out_empty(out_empty), .out_data(out_data),
      .o_vc_id(o_vc_id), .o_noc_dst(o_noc_dst), .o_drop_cnt(o_drop_cnt)
   );

   function automatic logic [511:0] fill(input logic [7:0] seed);
      logic [511:0] d;
      for (int k = 0; k < 64; k++) d[511-8*k -: 8] = seed + 8'(k);
      return d;
   endfunction

   function automatic logic [511:0] mk_sop(input logic [7:0] seed, input logic [6:0] p);
      logic [511:0] d;
      d = fill(seed);
      d[478:472] = p;
      d[452:421] = 32'hC0A80001;
      d[420:389] = 32'hC0A800C7;
      return d;
   endfunction

   function automatic logic [511:0] sop_out(input logic [511:0] d, input logic [6:0] p);
      d[478:472] = p - 7'd20;
      return d;
   endfunction

   function automatic logic [511:0] put_hdr(input logic [511:0] d, input int h, input logic [159:0] hdr);
      d[511-8*h -: 160] = hdr;
      return d;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Ready pattern changes at posedge+2 so both DUT and monitor see a stable value.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         out_ready = !(cyc >= stall_at && cyc < stall_at + 5);
      end
   end

   task automatic send(input logic [511:0] d, input logic s, input logic e, input logic er,
                       input logic [5:0] em, input logic [511:0] xd, input logic xe, input logic fwd);
      bit ok;
      beat_t b;
      if (fwd) begin
         b.data = xd; b.sop = s; b.eop = e; b.err = xe; b.empty = em;
         exp_q.push_back(b);
      end
      in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e; in_error = er; in_empty = em;
      in_fwd = fwd;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(posedge clk);
         if (out_ready) ok = 1'b1;
      end
      if (!ok) begin
         errors++;
         checks++;
         $display("FAIL send_timeout: beat not accepted within 200 cycles");
      end
      #1;
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_error = 1'b0; in_fwd = 1'b0;
   endtask

   task automatic drain(input string name);
      repeat (4) @(negedge clk);
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
      chk({"drain_", name}, 64'(exp_q.size()), 0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare on every output handshake, then log input acceptances.
   initial begin
      beat_t e;
      int    t;
      forever begin
         @(negedge clk);
         if (out_valid) begin
            chk("noc_dst", 64'(o_noc_dst), 64'(DEST));
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got data %h sop %b eop %b, expected no beat",
                           out_data, out_sop, out_eop);
               end else begin
                  e = exp_q.pop_front();
                  t = (tag_q.size() != 0) ? tag_q.pop_front() : -1000;
                  checks++;
                  if (out_data !== e.data) begin
                     errors++;
                     $display("FAIL data: got %h expected %h", out_data, e.data);
                  end
                  chk("flags_sop_eop_err_empty", {out_sop, out_eop, out_error, out_empty},
                      {e.sop, e.eop, e.err, e.empty});
                  chk("latency", 64'(rdy_cnt - t), 3);
               end
            end
         end else begin
            checks++;
            if (out_data !== '0 || out_sop !== 1'b0 || out_eop !== 1'b0 || out_error !== 1'b0 ||
                out_empty !== '0 || o_noc_dst !== '0) begin
               errors++;
               $display("FAIL idle_zero: got sop %b eop %b err %b empty %0h dst %0h, expected all 0",
                        out_sop, out_eop, out_error, out_empty, o_noc_dst);
            end
         end
         chk("vc_id", 64'(o_vc_id), 0);
         if (!reset && in_valid && out_ready && in_fwd) tag_q.push_back(rdy_cnt);
         if (out_ready) rdy_cnt++;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [511:0] d0, d1, b;
      reset = 1'b1;
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_error = 1'b0;
      in_empty = '0; in_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_drop_cnt", 64'(o_drop_cnt), 0);
      chk("rst_noc_dst", 64'(o_noc_dst), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      chk("ready_follows", 64'(in_ready), 64'(out_ready));

      // P=20: header at byte 0
      d0 = mk_sop(8'h10, 7'd20);
      send(d0, 1, 0, 0, 6'd0, sop_out(d0, 7'd20), 0, 1);
      b = fill(8'h80);
      send(put_hdr(b, 0, HDR_IN), 0, 1, 0, 6'd3, put_hdr(b, 0, HDR_OUT), 0, 1);
      drain("p20");

      // P=44: header at byte 24, input error propagates
      d0 = mk_sop(8'h20, 7'd44);
      send(d0, 1, 0, 0, 6'd0, sop_out(d0, 7'd44), 0, 1);
      b = fill(8'h90);
      send(put_hdr(b, 24, HDR_IN), 0, 1, 1, 6'd0, put_hdr(b, 24, HDR_OUT), 1, 1);
      drain("p44");

      // P=64: header ends at the last byte
      d0 = mk_sop(8'h25, 7'd64);
      send(d0, 1, 0, 0, 6'd0, sop_out(d0, 7'd64), 0, 1);
      b = fill(8'h05);
      send(put_hdr(b, 44, HDR_IN), 0, 1, 0, 6'd9, put_hdr(b, 44, HDR_OUT), 0, 1);
      drain("p64");

      // 3-beat packet with a 5-cycle backpressure window mid-packet
      d0 = mk_sop(8'h30, 7'd20);
      d1 = fill(8'hA0);
      b  = fill(8'hC0);
      stall_at = cyc + 3;
      send(d0, 1, 0, 0, 6'd0, sop_out(d0, 7'd20), 0, 1);
      send(put_hdr(d1, 0, HDR_IN), 0, 0, 0, 6'd0, put_hdr(d1, 0, HDR_OUT), 0, 1);
      send(b, 0, 1, 0, 6'd17, b, 0, 1);
      drain("stall");

      // P=10 and P=65: untouched, error on every beat
      d0 = mk_sop(8'h40, 7'd10);
      d1 = put_hdr(fill(8'h50), 0, HDR_IN);
      b  = fill(8'h60);
      send(d0, 1, 0, 0, 6'd0, d0, 1, 1);
      send(d1, 0, 0, 0, 6'd0, d1, 1, 1);
      send(b, 0, 1, 0, 6'd2, b, 1, 1);
      d0 = mk_sop(8'h45, 7'd65);
      d1 = put_hdr(fill(8'h55), 0, HDR_IN);
      send(d0, 1, 0, 0, 6'd0, d0, 1, 1);
      send(d1, 0, 1, 0, 6'd0, d1, 1, 1);
      drain("bad_p");

      // SOP arriving in HDR restarts the packet
      d0 = mk_sop(8'h11, 7'd20);
      d1 = mk_sop(8'h22, 7'd44);
      b  = fill(8'h33);
      send(d0, 1, 0, 0, 6'd0, sop_out(d0, 7'd20), 0, 1);
      send(d1, 1, 0, 0, 6'd0, sop_out(d1, 7'd44), 0, 1);
      send(put_hdr(b, 24, HDR_IN), 0, 1, 0, 6'd0, put_hdr(b, 24, HDR_OUT), 0, 1);
      drain("restart");

      // single-beat packet, then two stray beats in IDLE
      d0 = mk_sop(8'h77, 7'd20);
      send(d0, 1, 1, 0, 6'd0, d0, 1, 1);
      send(fill(8'h44), 0, 0, 0, 6'd0, '0, 0, 0);
      send(fill(8'h48), 0, 1, 0, 6'd0, '0, 0, 0);
      drain("stray");
      chk("drop_cnt_two", 64'(o_drop_cnt), 2);

      // reset while in BODY with beats still in the pipeline
      d0 = mk_sop(8'h5A, 7'd20);
      send(d0, 1, 0, 0, 6'd0, '0, 0, 0);
      send(put_hdr(fill(8'h66), 0, HDR_IN), 0, 0, 0, 6'd0, '0, 0, 0);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst2_drop_cnt", 64'(o_drop_cnt), 0);
      chk("rst2_out_valid", 64'(out_valid), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      send(fill(8'h70), 0, 0, 0, 6'd0, '0, 0, 0);
      d0 = mk_sop(8'h12, 7'd44);
      b  = fill(8'h9C);
      send(d0, 1, 0, 0, 6'd0, sop_out(d0, 7'd44), 0, 1);
      send(put_hdr(b, 24, HDR_IN), 0, 1, 0, 6'd1, put_hdr(b, 24, HDR_OUT), 0, 1);
      drain("post_reset");
      chk("drop_cnt_post_reset", 64'(o_drop_cnt), 1);

      repeat (5) @(posedge clk);
      chk("leftover_tags", 64'(tag_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ipv4_deparse_512.md
IPV4_DEPARSE_512 -- requirements
Module: ipv4_deparse_512

Interface
REQ-001 SHALL have parameter NODE_ID, default 4, node number used in log messages.
REQ-002 SHALL have parameter NOC_RADIX, default 16, NoC port count; sets o_noc_dst width.
REQ-003 SHALL have parameter NUM_VC, default 2, VC count; sets o_vc_id width.
REQ-004 SHALL have parameter DEST_PORT, default 4'd0, NoC destination for all output traffic.
REQ-005 SHALL have parameter DEFAULT_TTL, default 8'd64, TTL written into every generated header.
REQ-006 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port: reset  input  1  synchronous, active-high.
REQ-008 SHALL have port: in  avalonST.sink  valid/ready/sop/eop/error 1 each, empty 6, data 512  packet input.
REQ-009 SHALL have port: out  avalonST.src  same fields  packet output.
REQ-010 SHALL have port: o_vc_id  output  $clog2(NUM_VC)  always 0.
REQ-011 SHALL have port: o_noc_dst  output  $clog2(NOC_RADIX)  DEST_PORT while out.valid, else 0.
REQ-012 SHALL have port: o_drop_cnt  output  16  saturating count of discarded beats.

Function
REQ-013 SHALL use this byte numbering: byte k of a beat = data[511-8k -: 8].
REQ-014 SHALL drive in.ready = out.ready combinationally.
REQ-015 SHALL pass each accepted beat through 3 register stages: out after exactly 3 cycles with out.ready high.
REQ-016 SHALL hold all stages while out.ready is low; no beat lost or duplicated.
REQ-017 SHALL run FSM IDLE/HDR/BODY; reset state IDLE.
REQ-018 SHALL, in IDLE on valid&&sop: latch P = data[478:472], SRC = data[452:421], DST = data[420:389]; write P-20 into the output offset field; go to HDR, or stay IDLE if eop.
REQ-019 SHALL treat valid&&!sop in IDLE as a stray beat: not forwarded, o_drop_cnt+1, saturating at 16'hFFFF.
REQ-020 SHALL, in HDR on valid with H = P-20: write byte H = 8'h45, byte H+8 = DEFAULT_TTL, bytes H+12..15 = SRC, bytes H+16..19 = DST, and bytes H+10..11 = checksum; pass all other bytes unchanged.
REQ-021 SHALL, in HDR on valid, go to IDLE if eop, else BODY.
REQ-022 SHALL, in BODY, go to IDLE on valid&&eop; all other beats pass unchanged.
REQ-023 SHALL, on valid&&sop in HDR or BODY, handle that beat as a new SOP per REQ-018 (restart); beats already emitted are unaffected.
REQ-024 SHALL compute the checksum as the one's complement of the one's-complement sum of the ten 16-bit header words after patching, with the checksum field taken as 0.
REQ-025 SHALL pipeline the checksum: stage 1 forms five 17-bit pair sums; stage 2 forms a 20-bit total; stage 3 folds carries twice into 16 bits, inverts, and inserts.
REQ-026 SHALL, if P<20 or P>64, leave all bytes unmodified and set error=1 on every beat of that packet.
REQ-027 SHALL set error=1 on a single-beat packet (sop&&eop), with data unmodified.
REQ-028 SHALL OR the input error into the output error.
REQ-029 SHALL drive out.valid only from a valid stage-3 beat; all out fields are 0 when out.valid=0.

Reset
REQ-030 SHALL, while reset is high: clear all stage valid bits, set FSM to IDLE, set o_drop_cnt = 0, hold out.* = 0 and o_noc_dst = 0.
REQ-031 SHALL, on reset mid-packet, discard the partial packet; the first post-reset beat must be an SOP to be forwarded.

Verification
REQ-032 SHALL cover: SOP P=20 SRC=C0A80001 DST=C0A800C7, beat1 bytes 0-19 = 45 00 00 73 00 00 40 00 00 11 00 00 00.., eop -> beat1 checksum bytes = B8 61, TTL 40, output offset field 0.
REQ-033 SHALL cover: same packet with P=44 -> header at bytes 24-43, checksum B861; bytes 0-23 and 44-63 unchanged.
REQ-034 SHALL cover: 3-beat packet with out.ready low for 5 cycles mid-packet -> identical output beats, no gaps or duplicates; latency 3 ready cycles.
REQ-035 SHALL cover: P=10 -> data unmodified, error=1 on all beats.
REQ-036 SHALL cover: two non-SOP beats in IDLE -> nothing forwarded, o_drop_cnt=2.
REQ-037 SHALL cover: reset asserted in BODY, then a new packet -> no stale beat emitted; new packet patched correctly.
